// File: rtl/npc_pkg.sv
// Shared types and constants for the core front end and its memory arbiter.
package npc_pkg;

    localparam logic [31:0] RESET_PC = 32'h8000_0000;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT
    } arb_state_e;

    typedef enum logic {
        OWN_IFU,
        OWN_LSU
    } owner_e;

endpackage

// File: rtl/arb_rr2.sv
// Two-way round-robin grant: a lone requester wins, a conflict goes to whoever was not granted last.
module arb_rr2
    import npc_pkg::*;
(
    input  logic   i_ifu_valid,
    input  logic   i_lsu_valid,
    input  owner_e i_last_grant,
    output logic   o_gnt_ifu_c,
    output logic   o_gnt_lsu_c
);

    assign o_gnt_ifu_c = i_ifu_valid && (!i_lsu_valid || (i_last_grant == OWN_LSU));
    assign o_gnt_lsu_c = i_lsu_valid && (!i_ifu_valid || (i_last_grant == OWN_IFU));

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-outstanding memory port between the fetch unit and the load/store unit.
// Each access runs accept -> issue -> wait response -> route response.
module mem_arbiter
    import npc_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst,

    input  logic                    ifu_req_valid,
    output logic                    ifu_req_ready,
    input  logic [ADDR_WIDTH-1:0]   ifu_raddr,
    output logic                    ifu_resp_valid,
    output logic [DATA_WIDTH-1:0]   ifu_rdata,

    input  logic                    lsu_req_valid,
    output logic                    lsu_req_ready,
    input  logic                    lsu_wen,
    input  logic [ADDR_WIDTH-1:0]   lsu_addr,
    input  logic [DATA_WIDTH-1:0]   lsu_wdata,
    input  logic [DATA_WIDTH/8-1:0] lsu_wmask,
    output logic                    lsu_resp_valid,
    output logic [DATA_WIDTH-1:0]   lsu_rdata,

    output logic                    mem_req_valid,
    input  logic                    mem_req_ready,
    output logic                    mem_wen,
    output logic [ADDR_WIDTH-1:0]   mem_addr,
    output logic [DATA_WIDTH-1:0]   mem_wdata,
    output logic [DATA_WIDTH/8-1:0] mem_wmask,
    input  logic                    mem_resp_valid,
    input  logic [DATA_WIDTH-1:0]   mem_rdata
);

    localparam int unsigned MASK_WIDTH = DATA_WIDTH / 8;

    arb_state_e             r_state;
    owner_e                 r_owner;
    owner_e                 r_last_grant;
    logic                   r_mem_req_valid;
    logic                   r_mem_wen;
    logic [ADDR_WIDTH-1:0]  r_mem_addr;
    logic [DATA_WIDTH-1:0]  r_mem_wdata;
    logic [MASK_WIDTH-1:0]  r_mem_wmask;
    logic                   r_ifu_resp_valid;
    logic [DATA_WIDTH-1:0]  r_ifu_rdata;
    logic                   r_lsu_resp_valid;
    logic [DATA_WIDTH-1:0]  r_lsu_rdata;

    logic                   w_gnt_ifu;
    logic                   w_gnt_lsu;
    logic                   w_ifu_hs;
    logic                   w_lsu_hs;
    logic                   w_route;

    arb_rr2 u_arb_rr2 (
        .i_ifu_valid  (ifu_req_valid),
        .i_lsu_valid  (lsu_req_valid),
        .i_last_grant (r_last_grant),
        .o_gnt_ifu_c  (w_gnt_ifu),
        .o_gnt_lsu_c  (w_gnt_lsu)
    );

    // Ready is held low during reset so nothing is accepted on the reset edge.
    assign ifu_req_ready = !rst && (r_state == IDLE) && w_gnt_ifu;
    assign lsu_req_ready = !rst && (r_state == IDLE) && w_gnt_lsu;
    assign w_ifu_hs      = ifu_req_valid && ifu_req_ready;
    assign w_lsu_hs      = lsu_req_valid && lsu_req_ready;

    // A response counts only while an access is outstanding, including the same-cycle accept case.
    assign w_route = mem_resp_valid &&
                     ((r_state == WAIT) || ((r_state == REQ) && mem_req_ready));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state          <= IDLE;
            r_owner          <= OWN_IFU;
            r_last_grant     <= OWN_IFU;
            r_mem_req_valid  <= 1'b0;
            r_mem_wen        <= 1'b0;
            r_mem_addr       <= '0;
            r_mem_wdata      <= '0;
            r_mem_wmask      <= '0;
            r_ifu_resp_valid <= 1'b0;
            r_ifu_rdata      <= '0;
            r_lsu_resp_valid <= 1'b0;
            r_lsu_rdata      <= '0;
        end else begin
            r_ifu_resp_valid <= 1'b0;
            r_lsu_resp_valid <= 1'b0;

            if (w_route) begin
                if (r_owner == OWN_IFU) begin
                    r_ifu_resp_valid <= 1'b1;
                    r_ifu_rdata      <= mem_rdata;
                end else begin
                    r_lsu_resp_valid <= 1'b1;
                    r_lsu_rdata      <= r_mem_wen ? '0 : mem_rdata;
                end
            end

            case (r_state)
                IDLE: begin
                    if (w_ifu_hs) begin
                        r_owner         <= OWN_IFU;
                        r_last_grant    <= OWN_IFU;
                        r_mem_wen       <= 1'b0;
                        r_mem_addr      <= ifu_raddr;
                        r_mem_wdata     <= '0;
                        r_mem_wmask     <= '0;
                        r_mem_req_valid <= 1'b1;
                        r_state         <= REQ;
                    end else if (w_lsu_hs) begin
                        r_owner         <= OWN_LSU;
                        r_last_grant    <= OWN_LSU;
                        r_mem_wen       <= lsu_wen;
                        r_mem_addr      <= lsu_addr;
                        r_mem_wdata     <= lsu_wdata;
                        r_mem_wmask     <= lsu_wen ? lsu_wmask : '0;
                        r_mem_req_valid <= 1'b1;
                        r_state         <= REQ;
                    end
                end
                REQ: begin
                    if (mem_req_ready) begin
                        r_mem_req_valid <= 1'b0;
                        r_state         <= mem_resp_valid ? IDLE : WAIT;
                    end
                end
                WAIT: begin
                    if (mem_resp_valid) begin
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_mem_req_valid <= 1'b0;
                    r_state         <= IDLE;
                end
            endcase
        end
    end

    assign mem_req_valid  = r_mem_req_valid;
    assign mem_wen        = r_mem_wen;
    assign mem_addr       = r_mem_addr;
    assign mem_wdata      = r_mem_wdata;
    assign mem_wmask      = r_mem_wmask;
    assign ifu_resp_valid = r_ifu_resp_valid;
    assign ifu_rdata      = r_ifu_rdata;
    assign lsu_resp_valid = r_lsu_resp_valid;
    assign lsu_rdata      = r_lsu_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a configurable memory responder plus one task per scenario.
module tb_mem_arbiter;
    import npc_pkg::*;

    logic        clk;
    logic        rst;
    logic        ifu_req_valid;
    logic        ifu_req_ready;
    logic [31:0] ifu_raddr;
    logic        ifu_resp_valid;
    logic [31:0] ifu_rdata;
    logic        lsu_req_valid;
    logic        lsu_req_ready;
    logic        lsu_wen;
    logic [31:0] lsu_addr;
    logic [31:0] lsu_wdata;
    logic [3:0]  lsu_wmask;
    logic        lsu_resp_valid;
    logic [31:0] lsu_rdata;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic        mem_wen;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wmask;
    logic        mem_resp_valid;
    logic [31:0] mem_rdata;

    int n_vec;
    int n_err;

    mem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .clk            (clk),
        .rst            (rst),
        .ifu_req_valid  (ifu_req_valid),
        .ifu_req_ready  (ifu_req_ready),
        .ifu_raddr      (ifu_raddr),
        .ifu_resp_valid (ifu_resp_valid),
        .ifu_rdata      (ifu_rdata),
        .lsu_req_valid  (lsu_req_valid),
        .lsu_req_ready  (lsu_req_ready),
        .lsu_wen        (lsu_wen),
        .lsu_addr       (lsu_addr),
        .lsu_wdata      (lsu_wdata),
        .lsu_wmask      (lsu_wmask),
        .lsu_resp_valid (lsu_resp_valid),
        .lsu_rdata      (lsu_rdata),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_wen        (mem_wen),
        .mem_addr       (mem_addr),
        .mem_wdata      (mem_wdata),
        .mem_wmask      (mem_wmask),
        .mem_resp_valid (mem_resp_valid),
        .mem_rdata      (mem_rdata)
    );

    always #5 clk = ~clk;

    // Memory contents seen by reads.
    function automatic logic [31:0] mem_lookup(input logic [31:0] a);
        case (a)
            32'h8000_0000: return 32'h0000_0013;
            32'h8000_0004: return 32'h0000_0297;
            32'h8000_0008: return 32'h0102_0304;
            32'h8000_000C: return 32'h0506_0708;
            32'h8000_0200: return 32'hCAFE_F00D;
            default:       return 32'hBAD0_0000;
        endcase
    endfunction

    // Responder: ready after cfg_ready_delay REQ cycles, response cfg_resp_delay cycles after accept.
    int          cfg_ready_delay;
    int          cfg_resp_delay;
    int          req_wait_cnt;
    int          pend_cnt;
    logic [31:0] pend_data;

    initial begin
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b0;
        mem_rdata      = '0;
        req_wait_cnt   = 0;
        pend_cnt       = 0;
        pend_data      = '0;
        forever begin
            @(negedge clk);
            mem_req_ready  = 1'b0;
            mem_resp_valid = 1'b0;
            if (pend_cnt > 0) begin
                pend_cnt--;
                if (pend_cnt == 0) begin
                    mem_resp_valid = 1'b1;
                    mem_rdata      = pend_data;
                end
            end else if (mem_req_valid === 1'b1) begin
                if (req_wait_cnt < cfg_ready_delay) begin
                    req_wait_cnt++;
                end else begin
                    logic [31:0] d;
                    req_wait_cnt  = 0;
                    mem_req_ready = 1'b1;
                    d = mem_wen ? 32'hFFFF_FFFF : mem_lookup(mem_addr);
                    if (cfg_resp_delay == 0) begin
                        mem_resp_valid = 1'b1;
                        mem_rdata      = d;
                    end else begin
                        pend_cnt  = cfg_resp_delay;
                        pend_data = d;
                    end
                end
            end
        end
    end

    // Observation log, sampled mid-cycle once inputs have settled.
    int          cyc;
    int          hs_ifu_cnt;
    int          hs_lsu_cnt;
    int          hs_who_q[$];
    int          hs_cyc_q[$];
    int          ifu_resp_cnt;
    int          lsu_resp_cnt;
    int          ifu_resp_cyc;
    logic [31:0] ifu_data_q[$];
    logic [31:0] lsu_data_q[$];

    initial begin
        cyc = 0;
        forever begin
            @(negedge clk);
            #2;
            cyc++;
            if (ifu_req_valid && ifu_req_ready) begin
                hs_ifu_cnt++;
                hs_who_q.push_back(0);
                hs_cyc_q.push_back(cyc);
            end
            if (lsu_req_valid && lsu_req_ready) begin
                hs_lsu_cnt++;
                hs_who_q.push_back(1);
                hs_cyc_q.push_back(cyc);
            end
            if (ifu_resp_valid === 1'b1) begin
                ifu_resp_cnt++;
                ifu_resp_cyc = cyc;
                ifu_data_q.push_back(ifu_rdata);
            end
            if (lsu_resp_valid === 1'b1) begin
                lsu_resp_cnt++;
                lsu_data_q.push_back(lsu_rdata);
            end
        end
    end

    task automatic clear_mon();
        hs_ifu_cnt   = 0;
        hs_lsu_cnt   = 0;
        ifu_resp_cnt = 0;
        lsu_resp_cnt = 0;
        ifu_resp_cyc = -1;
        hs_who_q.delete();
        hs_cyc_q.delete();
        ifu_data_q.delete();
        lsu_data_q.delete();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        ifu_req_valid = 1'b0;
        lsu_req_valid = 1'b0;
        repeat (2) @(negedge clk);
        n_vec++;
        if ({ifu_req_ready, lsu_req_ready, mem_req_valid, mem_wen} !== 4'b0000) begin
            n_err++;
            $display("FAIL reset_ctrl: got %b expected 0000",
                     {ifu_req_ready, lsu_req_ready, mem_req_valid, mem_wen});
        end
        n_vec++;
        if (mem_addr !== 32'h0 || mem_wdata !== 32'h0 || mem_wmask !== 4'h0) begin
            n_err++;
            $display("FAIL reset_mem: got addr=%h wdata=%h wmask=%h expected all 0",
                     mem_addr, mem_wdata, mem_wmask);
        end
        n_vec++;
        if ({ifu_resp_valid, lsu_resp_valid} !== 2'b00 || ifu_rdata !== 32'h0 || lsu_rdata !== 32'h0) begin
            n_err++;
            $display("FAIL reset_resp: got iv=%b lv=%b ird=%h lrd=%h expected all 0",
                     ifu_resp_valid, lsu_resp_valid, ifu_rdata, lsu_rdata);
        end
        ifu_req_valid = 1'b1;
        lsu_req_valid = 1'b1;
        #1;
        n_vec++;
        if ({ifu_req_ready, lsu_req_ready} !== 2'b00) begin
            n_err++;
            $display("FAIL reset_ready_gated: got %b expected 00", {ifu_req_ready, lsu_req_ready});
        end
        ifu_req_valid = 1'b0;
        lsu_req_valid = 1'b0;
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_ifu_only();
        clear_mon();
        cfg_ready_delay = 0;
        cfg_resp_delay  = 3;
        ifu_raddr     = RESET_PC;
        ifu_req_valid = 1'b1;
        #1;
        n_vec++;
        if ({ifu_req_ready, lsu_req_ready} !== 2'b10) begin
            n_err++;
            $display("FAIL ifu_ready: got %b expected 10", {ifu_req_ready, lsu_req_ready});
        end
        @(negedge clk);
        ifu_req_valid = 1'b0;
        n_vec++;
        if (mem_req_valid !== 1'b1 || mem_addr !== 32'h8000_0000 || mem_wen !== 1'b0 ||
            mem_wdata !== 32'h0 || mem_wmask !== 4'h0) begin
            n_err++;
            $display("FAIL ifu_issue: got v=%b a=%h w=%b d=%h m=%h expected 1 80000000 0 0 0",
                     mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask);
        end
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (i == 1) begin
                n_vec++;
                if (mem_req_valid !== 1'b0) begin
                    n_err++;
                    $display("FAIL ifu_wait_novalid: got %b expected 0", mem_req_valid);
                end
            end
        end
        n_vec++;
        if (ifu_resp_cnt != 1 || lsu_resp_cnt != 0) begin
            n_err++;
            $display("FAIL ifu_pulses: got ifu=%0d lsu=%0d expected 1 0", ifu_resp_cnt, lsu_resp_cnt);
        end else begin
            n_vec++;
            if (ifu_data_q[0] !== 32'h0000_0013) begin
                n_err++;
                $display("FAIL ifu_rdata: got %h expected 00000013", ifu_data_q[0]);
            end
            n_vec++;
            if (hs_cyc_q.size() != 1 || (ifu_resp_cyc - hs_cyc_q[0]) != 5) begin
                n_err++;
                $display("FAIL ifu_latency: got %0d expected 5",
                         hs_cyc_q.size() == 1 ? ifu_resp_cyc - hs_cyc_q[0] : -1);
            end
        end
    endtask

    task automatic test_alternation();
        int bad_ready;
        clear_mon();
        bad_ready = 0;
        cfg_ready_delay = 0;
        cfg_resp_delay  = 1;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        ifu_req_valid = 1'b1;
        ifu_raddr     = 32'h8000_0004;
        lsu_req_valid = 1'b1;
        lsu_wen       = 1'b0;
        lsu_addr      = 32'h8000_0200;
        lsu_wdata     = 32'h1111_2222;
        lsu_wmask     = 4'hF;
        #1;
        n_vec++;
        if ({ifu_req_ready, lsu_req_ready} !== 2'b01) begin
            n_err++;
            $display("FAIL alt_first_lsu: got ifu/lsu ready %b expected 01", {ifu_req_ready, lsu_req_ready});
        end
        @(negedge clk);
        n_vec++;
        if (mem_addr !== 32'h8000_0200 || mem_wen !== 1'b0 || mem_wmask !== 4'h0) begin
            n_err++;
            $display("FAIL alt_lsu_read_issue: got a=%h w=%b m=%h expected 80000200 0 0",
                     mem_addr, mem_wen, mem_wmask);
        end
        for (int i = 0; i < 16; i++) begin
            if (i > 0) @(negedge clk);
            if (hs_ifu_cnt >= 1) ifu_req_valid = 1'b0;
            if (hs_lsu_cnt >= 2) lsu_req_valid = 1'b0;
            #1;
            if (mem_req_valid && (ifu_req_ready || lsu_req_ready)) bad_ready++;
        end
        @(negedge clk);
        n_vec++;
        if (bad_ready != 0) begin
            n_err++;
            $display("FAIL alt_busy_ready: got %0d ready cycles in REQ expected 0", bad_ready);
        end
        n_vec++;
        if (hs_who_q.size() != 3 || hs_who_q[0] != 1 || hs_who_q[1] != 0 || hs_who_q[2] != 1) begin
            n_err++;
            $display("FAIL alt_order: got %0d grants first=%0d second=%0d expected 3 grants LSU,IFU,LSU (1,0,1)",
                     hs_who_q.size(), hs_who_q.size() > 0 ? hs_who_q[0] : -1,
                     hs_who_q.size() > 1 ? hs_who_q[1] : -1);
        end
        n_vec++;
        if (ifu_data_q.size() != 1 || lsu_data_q.size() != 2) begin
            n_err++;
            $display("FAIL alt_pulses: got ifu=%0d lsu=%0d expected 1 2", ifu_data_q.size(), lsu_data_q.size());
        end else if (ifu_data_q[0] !== 32'h0000_0297 || lsu_data_q[0] !== 32'hCAFE_F00D ||
                     lsu_data_q[1] !== 32'hCAFE_F00D) begin
            n_err++;
            $display("FAIL alt_rdata: got ifu=%h lsu=%h,%h expected 00000297 cafef00d,cafef00d",
                     ifu_data_q[0], lsu_data_q[0], lsu_data_q[1]);
        end
    endtask

    task automatic test_lsu_write();
        clear_mon();
        cfg_ready_delay = 0;
        cfg_resp_delay  = 1;
        lsu_req_valid = 1'b1;
        lsu_wen       = 1'b1;
        lsu_addr      = 32'h8000_0100;
        lsu_wdata     = 32'hDEAD_BEEF;
        lsu_wmask     = 4'hF;
        #1;
        n_vec++;
        if (lsu_req_ready !== 1'b1) begin
            n_err++;
            $display("FAIL wr_ready: got %b expected 1", lsu_req_ready);
        end
        @(negedge clk);
        lsu_req_valid = 1'b0;
        lsu_wen       = 1'b0;
        n_vec++;
        if (mem_req_valid !== 1'b1 || mem_wen !== 1'b1 || mem_wmask !== 4'hF ||
            mem_wdata !== 32'hDEAD_BEEF || mem_addr !== 32'h8000_0100) begin
            n_err++;
            $display("FAIL wr_issue: got v=%b w=%b m=%h d=%h a=%h expected 1 1 f deadbeef 80000100",
                     mem_req_valid, mem_wen, mem_wmask, mem_wdata, mem_addr);
        end
        repeat (6) @(negedge clk);
        n_vec++;
        if (lsu_resp_cnt != 1 || ifu_resp_cnt != 0) begin
            n_err++;
            $display("FAIL wr_pulses: got lsu=%0d ifu=%0d expected 1 0", lsu_resp_cnt, ifu_resp_cnt);
        end else if (lsu_data_q[0] !== 32'h0) begin
            n_err++;
            $display("FAIL wr_ack_rdata: got %h expected 00000000", lsu_data_q[0]);
        end
    endtask

    task automatic test_stall();
        clear_mon();
        cfg_ready_delay = 3;
        cfg_resp_delay  = 0;
        ifu_raddr     = 32'h8000_0008;
        ifu_req_valid = 1'b1;
        @(negedge clk);
        ifu_req_valid = 1'b0;
        lsu_req_valid = 1'b1;
        lsu_wen       = 1'b0;
        lsu_addr      = 32'h8000_0300;
        for (int k = 0; k < 4; k++) begin
            if (k > 0) @(negedge clk);
            n_vec++;
            if (mem_req_valid !== 1'b1 || mem_addr !== 32'h8000_0008) begin
                n_err++;
                $display("FAIL stall_hold[%0d]: got v=%b a=%h expected 1 80000008", k, mem_req_valid, mem_addr);
            end
            #1;
            n_vec++;
            if ({ifu_req_ready, lsu_req_ready} !== 2'b00) begin
                n_err++;
                $display("FAIL stall_no_ready[%0d]: got %b expected 00", k, {ifu_req_ready, lsu_req_ready});
            end
        end
        @(negedge clk);
        n_vec++;
        if (ifu_resp_valid !== 1'b1 || ifu_rdata !== 32'h0102_0304 || lsu_resp_valid !== 1'b0) begin
            n_err++;
            $display("FAIL stall_same_cycle_resp: got iv=%b ird=%h lv=%b expected 1 01020304 0",
                     ifu_resp_valid, ifu_rdata, lsu_resp_valid);
        end
        #1;
        n_vec++;
        if (lsu_req_ready !== 1'b1) begin
            n_err++;
            $display("FAIL stall_back_idle: got lsu ready %b expected 1", lsu_req_ready);
        end
        lsu_req_valid = 1'b0;
        @(negedge clk);
        n_vec++;
        if (mem_req_valid !== 1'b0 || ifu_resp_valid !== 1'b0) begin
            n_err++;
            $display("FAIL stall_withdrawn: got mv=%b iv=%b expected 0 0", mem_req_valid, ifu_resp_valid);
        end
        cfg_ready_delay = 0;
    endtask

    task automatic test_reset_mid();
        clear_mon();
        cfg_ready_delay = 0;
        cfg_resp_delay  = 4;
        ifu_raddr     = 32'h8000_0004;
        ifu_req_valid = 1'b1;
        @(negedge clk);
        ifu_req_valid = 1'b0;
        @(negedge clk);
        n_vec++;
        if (mem_req_valid !== 1'b0 || mem_addr !== 32'h8000_0004) begin
            n_err++;
            $display("FAIL rstmid_in_wait: got v=%b a=%h expected 0 80000004", mem_req_valid, mem_addr);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_vec++;
        if ({ifu_req_ready, lsu_req_ready, mem_req_valid, mem_wen, ifu_resp_valid, lsu_resp_valid} !== 6'b0 ||
            mem_addr !== 32'h0 || mem_wdata !== 32'h0 || mem_wmask !== 4'h0 ||
            ifu_rdata !== 32'h0 || lsu_rdata !== 32'h0) begin
            n_err++;
            $display("FAIL rstmid_zero: got ctl=%b a=%h d=%h m=%h ird=%h lrd=%h expected all 0",
                     {ifu_req_ready, lsu_req_ready, mem_req_valid, mem_wen, ifu_resp_valid, lsu_resp_valid},
                     mem_addr, mem_wdata, mem_wmask, ifu_rdata, lsu_rdata);
        end
        repeat (8) @(negedge clk);
        n_vec++;
        if (ifu_resp_cnt != 0 || lsu_resp_cnt != 0 || mem_req_valid !== 1'b0) begin
            n_err++;
            $display("FAIL rstmid_stale_resp: got ifu=%0d lsu=%0d mv=%b expected 0 0 0",
                     ifu_resp_cnt, lsu_resp_cnt, mem_req_valid);
        end
    endtask

    task automatic test_back_to_back();
        int nhs;
        logic hs_pending;
        clear_mon();
        cfg_ready_delay = 0;
        cfg_resp_delay  = 1;
        nhs        = 0;
        hs_pending = 1'b0;
        ifu_raddr     = 32'h8000_0000;
        ifu_req_valid = 1'b1;
        for (int c = 0; c < 20; c++) begin
            if (c > 0) @(negedge clk);
            if (hs_pending) begin
                ifu_raddr  = ifu_raddr + 32'd4;
                nhs++;
                hs_pending = 1'b0;
                if (nhs == 4) ifu_req_valid = 1'b0;
            end
            #1;
            if (ifu_req_valid && ifu_req_ready) hs_pending = 1'b1;
        end
        repeat (4) @(negedge clk);
        n_vec++;
        if (hs_cyc_q.size() != 4) begin
            n_err++;
            $display("FAIL b2b_count: got %0d handshakes expected 4", hs_cyc_q.size());
        end else begin
            for (int j = 1; j < 4; j++) begin
                n_vec++;
                if (hs_cyc_q[j] - hs_cyc_q[j-1] != 3) begin
                    n_err++;
                    $display("FAIL b2b_period[%0d]: got %0d cycles expected 3", j, hs_cyc_q[j] - hs_cyc_q[j-1]);
                end
            end
        end
        n_vec++;
        if (ifu_data_q.size() != 4 || lsu_resp_cnt != 0) begin
            n_err++;
            $display("FAIL b2b_pulses: got ifu=%0d lsu=%0d expected 4 0", ifu_data_q.size(), lsu_resp_cnt);
        end else begin
            n_vec++;
            if (ifu_data_q[0] !== 32'h0000_0013 || ifu_data_q[1] !== 32'h0000_0297 ||
                ifu_data_q[2] !== 32'h0102_0304 || ifu_data_q[3] !== 32'h0506_0708) begin
                n_err++;
                $display("FAIL b2b_order: got %h %h %h %h expected 00000013 00000297 01020304 05060708",
                         ifu_data_q[0], ifu_data_q[1], ifu_data_q[2], ifu_data_q[3]);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected $finish, %0d vectors %0d miscompares", n_vec, n_err);
        $fatal(1);
    end

    initial begin
        clk             = 1'b0;
        rst             = 1'b1;
        ifu_req_valid   = 1'b0;
        ifu_raddr       = '0;
        lsu_req_valid   = 1'b0;
        lsu_wen         = 1'b0;
        lsu_addr        = '0;
        lsu_wdata       = '0;
        lsu_wmask       = '0;
        cfg_ready_delay = 0;
        cfg_resp_delay  = 1;
        n_vec           = 0;
        n_err           = 0;
        clear_mon();

        test_reset();
        test_ifu_only();
        test_alternation();
        test_lsu_write();
        test_stall();
        test_reset_mid();
        test_back_to_back();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
